// File: rtl/i2c_write_master.sv
// ---------------------------------------------------------------------------
// i2c_write_master
//   I2C write-transaction master. It issues START, {dev_addr, W}, the
//   register address (MSB byte first), the payload (MSB byte first) and then
//   STOP. Every ACK is checked, and a NACK aborts straight to STOP. SCL
//   timing comes from a quarter-bit clock-enable divider. Slave clock
//   stretching freezes that divider. Pads are driven open-drain
//   (1 = release, 0 = pull low).
//
// Parameters
//   CLK_DIV  system clocks per quarter SCL bit period (>= 2)
//   ADDR_W   register address width, multiple of 8 (8..16)
//   DATA_W   payload width, multiple of 8 (8..32)
//
// Ports
//   clk       system clock
//   reset     synchronous active-high reset
//   start     request pulse, accepted only while busy = 0
//   dev_addr  7-bit slave address, latched on an accepted start
//   reg_addr  register address, latched on an accepted start
//   wdata     payload, latched on an accepted start
//   busy      transaction in progress
//   done      one-cycle pulse at the end of a transaction (ACK or NACK)
//   err       NACK seen in the last transaction
//   sda_in    SDA pad value (asynchronous, synchronised here)
//   sda_out   SDA open-drain control
//   scl_in    SCL pad value (asynchronous, synchronised here)
//   scl_out   SCL open-drain control
// ---------------------------------------------------------------------------
module i2c_write_master #(
  parameter int CLK_DIV = 125,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [6:0]        dev_addr,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              sda_in,
  output logic              sda_out,
  input  logic              scl_in,
  output logic              scl_out
);

  localparam int NBYTES  = 1 + ADDR_W / 8 + DATA_W / 8;
  localparam int SHIFT_W = 8 * NBYTES;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BYTE_W  = $clog2(NBYTES);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [1:0]          r_quarter;
  logic [1:0]          w_quarter_n;
  logic [2:0]          r_bit;
  logic [2:0]          w_bit_n;
  logic [BYTE_W-1:0]   r_byte;
  logic [BYTE_W-1:0]   w_byte_n;
  logic [SHIFT_W-1:0]  r_shift;
  logic [SHIFT_W-1:0]  w_shift_n;
  logic [DIV_W-1:0]    r_div;
  logic [1:0]          r_sda_sync;
  logic [1:0]          r_scl_sync;
  logic [1:0]          r_scl_out_d;
  logic                r_sda_out;
  logic                r_scl_out;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                w_err_n;
  logic                w_sda_n;
  logic                w_scl_n;
  logic                w_active;
  logic                w_stretch;
  logic                w_tick;
  logic                w_sda_s;
  logic                w_scl_s;

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign sda_out = r_sda_out;
  assign scl_out = r_scl_out;

  assign w_sda_s  = r_sda_sync[1];
  assign w_scl_s  = r_scl_sync[1];
  assign w_active = (r_state != ST_IDLE) && (r_state != ST_DONE);

  // The synchronised scl_in lags the pad by two cycles. Our own scl_out is
  // therefore compared through the same two-cycle delay. Without this, every
  // release of SCL would look like a two-cycle stretch.
  assign w_stretch = r_scl_out & r_scl_out_d[1] & ~w_scl_s;
  assign w_tick    = w_active & ~w_stretch & (r_div == DIV_LAST);

  // Double-flop the pad inputs and delay scl_out to match the scl_in lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sda_sync  <= 2'b11;
      r_scl_sync  <= 2'b11;
      r_scl_out_d <= 2'b11;
    end else begin
      r_sda_sync  <= {r_sda_sync[0], sda_in};
      r_scl_sync  <= {r_scl_sync[0], scl_in};
      r_scl_out_d <= {r_scl_out_d[0], r_scl_out};
    end
  end

  // Quarter-bit divider: held at zero when idle, frozen while stretched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= {DIV_W{1'b0}};
    end else if (!w_active) begin
      r_div <= {DIV_W{1'b0}};
    end else if (w_stretch) begin
      r_div <= r_div;
    end else if (w_tick) begin
      r_div <= {DIV_W{1'b0}};
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Next-state logic: one quarter step per tick.
  always_comb begin
    w_state_n   = r_state;
    w_quarter_n = r_quarter;
    w_bit_n     = r_bit;
    w_byte_n    = r_byte;
    w_shift_n   = r_shift;
    w_err_n     = r_err;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_n   = ST_START;
          w_quarter_n = 2'd0;
          w_bit_n     = 3'd0;
          w_byte_n    = {BYTE_W{1'b0}};
          w_shift_n   = {dev_addr, 1'b0, reg_addr, wdata};
          w_err_n     = 1'b0;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_quarter == 2'd1) begin
            w_state_n   = ST_BIT;
            w_quarter_n = 2'd0;
          end else begin
            w_quarter_n = r_quarter + 2'd1;
          end
        end else begin
          w_state_n = ST_START;
        end
      end
      ST_BIT: begin
        if (w_tick) begin
          if (r_quarter == 2'd3) begin
            w_quarter_n = 2'd0;
            w_shift_n   = {r_shift[SHIFT_W-2:0], 1'b0};
            if (r_bit == 3'd7) begin
              w_state_n = ST_ACK;
              w_bit_n   = 3'd0;
            end else begin
              w_bit_n = r_bit + 3'd1;
            end
          end else begin
            w_quarter_n = r_quarter + 2'd1;
          end
        end else begin
          w_state_n = ST_BIT;
        end
      end
      ST_ACK: begin
        if (w_tick) begin
          if (r_quarter == 2'd2) begin
            // ACK sample point: a high SDA here is a NACK. r_err was
            // cleared at start, so it marks the NACK for this transaction.
            w_err_n     = r_err | w_sda_s;
            w_quarter_n = 2'd3;
          end else if (r_quarter == 2'd3) begin
            w_quarter_n = 2'd0;
            if (r_err || (r_byte == BYTE_LAST)) begin
              w_state_n = ST_STOP;
            end else begin
              w_state_n = ST_BIT;
              w_byte_n  = r_byte + BYTE_W'(1);
            end
          end else begin
            w_quarter_n = r_quarter + 2'd1;
          end
        end else begin
          w_state_n = ST_ACK;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_quarter == 2'd2) begin
            w_state_n   = ST_DONE;
            w_quarter_n = 2'd0;
          end else begin
            w_quarter_n = r_quarter + 2'd1;
          end
        end else begin
          w_state_n = ST_STOP;
        end
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n   = ST_IDLE;
        w_quarter_n = 2'd0;
      end
    endcase
  end

  // Pad levels for the upcoming state. They are registered so that the
  // pads change on the same edge as the state.
  always_comb begin
    w_sda_n = 1'b1;
    w_scl_n = 1'b1;
    case (w_state_n)
      ST_IDLE: begin
        w_sda_n = 1'b1;
        w_scl_n = 1'b1;
      end
      ST_START: begin
        w_sda_n = 1'b0;
        w_scl_n = (w_quarter_n == 2'd0);
      end
      ST_BIT: begin
        w_sda_n = w_shift_n[SHIFT_W-1];
        w_scl_n = (w_quarter_n == 2'd1) || (w_quarter_n == 2'd2);
      end
      ST_ACK: begin
        w_sda_n = 1'b1;
        w_scl_n = (w_quarter_n == 2'd1) || (w_quarter_n == 2'd2);
      end
      ST_STOP: begin
        w_sda_n = (w_quarter_n == 2'd2);
        w_scl_n = (w_quarter_n != 2'd0);
      end
      ST_DONE: begin
        w_sda_n = 1'b1;
        w_scl_n = 1'b1;
      end
      default: begin
        w_sda_n = 1'b1;
        w_scl_n = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_quarter <= 2'd0;
      r_bit     <= 3'd0;
      r_byte    <= {BYTE_W{1'b0}};
      r_shift   <= {SHIFT_W{1'b0}};
      r_err     <= 1'b0;
      r_sda_out <= 1'b1;
      r_scl_out <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_quarter <= w_quarter_n;
      r_bit     <= w_bit_n;
      r_byte    <= w_byte_n;
      r_shift   <= w_shift_n;
      r_err     <= w_err_n;
      r_sda_out <= w_sda_n;
      r_scl_out <= w_scl_n;
      r_busy    <= (w_state_n != ST_IDLE) && (w_state_n != ST_DONE);
      r_done    <= (w_state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_write_master
//   Two masters share one open-drain bus. dut_a is 8/8 bits and dut_b is
//   16/32 bits, and only one of them is started at a time. A slave model
//   decodes the bus and acknowledges bytes (with an optional NACK on a chosen
//   byte). It can also hold SCL low after a chosen SCL rise. The stimulus
//   pushes the expected bus bytes and the expected {err, latency} of each
//   transaction into queues. The slave pops bytes as it decodes them. A
//   separate monitor pops a transaction whenever done pulses.
// ---------------------------------------------------------------------------
module tb_i2c_write_master;

  localparam int DIV = 4;

  typedef struct {
    logic err;
    int   lat;
    logic cfg;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [6:0]  dev_a = 7'd0, dev_b = 7'd0;
  logic [7:0]  reg_a = 8'd0, data_a = 8'd0;
  logic [15:0] reg_b = 16'd0;
  logic [31:0] data_b = 32'd0;
  logic        busy_a, done_a, err_a, sda_out_a, scl_out_a;
  logic        busy_b, done_b, err_b, sda_out_b, scl_out_b;
  logic        slave_sda = 1'b1;
  logic        hold = 1'b0;
  logic        bus_scl, bus_sda, scl_in_w;

  assign bus_scl  = scl_out_a & scl_out_b;
  assign bus_sda  = sda_out_a & sda_out_b & slave_sda;
  assign scl_in_w = bus_scl & ~hold;

  i2c_write_master #(.CLK_DIV(DIV), .ADDR_W(8), .DATA_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .dev_addr(dev_a),
    .reg_addr(reg_a), .wdata(data_a), .busy(busy_a), .done(done_a),
    .err(err_a), .sda_in(bus_sda), .sda_out(sda_out_a), .scl_in(scl_in_w),
    .scl_out(scl_out_a));

  i2c_write_master #(.CLK_DIV(DIV), .ADDR_W(16), .DATA_W(32)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .dev_addr(dev_b),
    .reg_addr(reg_b), .wdata(data_b), .busy(busy_b), .done(done_b),
    .err(err_b), .sda_in(bus_sda), .sda_out(sda_out_b), .scl_in(scl_in_w),
    .scl_out(scl_out_b));

  always #5 clk = ~clk;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   t_start = 0;
  logic txn_seen = 1'b0;
  logic abort = 1'b0;
  logic last_err [2] = '{1'b0, 1'b0};

  logic [7:0] exp_bytes [$];
  txn_t       exp_txn [$];

  // slave configuration, set by the stimulus before each start
  int nack_at = -1;
  int stretch_at = 0;
  int stretch_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model: bus decoder, ACK/NACK driver and clock stretcher.
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic       in_txn = 1'b0, acking = 1'b0, stop_seen = 1'b0;
  logic       hold_sda = 1'b1, sda_moved = 1'b0;
  logic [7:0] sh = 8'd0;
  int         bitcnt = 0, bytecnt = 0, rises = 0, hold_cnt = 0;

  always @(negedge clk) begin
    if (abort) begin
      in_txn = 1'b0; acking = 1'b0; slave_sda = 1'b1;
      hold = 1'b0; hold_cnt = 0; abort = 1'b0;
    end else begin
      if (hold_cnt > 0) begin
        if (bus_sda !== hold_sda) sda_moved = 1'b1;
        hold_cnt--;
        if (hold_cnt == 0) begin
          hold = 1'b0;
          chk("stretch_sda_stable", sda_moved, 1'b0);
        end
      end
      if (p_scl && bus_scl && p_sda && !bus_sda) begin
        in_txn = 1'b1; bitcnt = 0; bytecnt = 0; rises = 0;
        acking = 1'b0; stop_seen = 1'b0;
      end else if (in_txn && p_scl && bus_scl && !p_sda && bus_sda) begin
        stop_seen = 1'b1; in_txn = 1'b0;
      end else if (in_txn && !p_scl && bus_scl) begin
        rises++;
        if (bitcnt < 8) begin
          sh = {sh[6:0], bus_sda};
          bitcnt++;
        end
        if (rises == stretch_at) begin
          hold = 1'b1; hold_cnt = stretch_len;
          hold_sda = bus_sda; sda_moved = 1'b0;
        end
      end else if (in_txn && p_scl && !bus_scl) begin
        if (acking) begin
          slave_sda = 1'b1; acking = 1'b0; bitcnt = 0; bytecnt++;
        end else if (bitcnt == 8) begin
          if (exp_bytes.size() == 0) chk("extra_bus_byte", sh, 64'hFFFF);
          else chk("bus_byte", sh, exp_bytes.pop_front());
          acking = 1'b1;
          slave_sda = (bytecnt == nack_at) ? 1'b1 : 1'b0;
        end
      end
    end
    p_scl = bus_scl;
    p_sda = bus_sda;
  end

  // Monitor: pops the expected transaction whenever done pulses.
  logic done_last = 1'b0;
  always @(negedge clk) begin
    txn_t t;
    if (done_last) chk("done_pulse_width", done_a | done_b, 1'b0);
    done_last = done_a | done_b;
    if (done_a || done_b) begin
      if (exp_txn.size() == 0) begin
        chk("unexpected_done", 1'b1, 1'b0);
      end else begin
        t = exp_txn.pop_front();
        chk("done_source", done_b, t.cfg);
        chk("done_latency", cyc - t_start - 1, t.lat);
        chk("err_flag", t.cfg ? err_b : err_a, t.err);
        chk("busy_at_done", t.cfg ? busy_b : busy_a, 1'b0);
        chk("bytes_missing", exp_bytes.size(), 0);
        chk("stop_seen", stop_seen, 1'b1);
      end
      txn_seen = 1'b1;
    end
  end

  // Reference model plus stimulus for one transaction. nack < 0 means the
  // slave ACKs every byte. s_at = 0 means no clock stretch.
  task automatic run_txn(input logic cfg, input logic [6:0] dev, input logic [31:0] ra,
                         input logic [31:0] wd, input int nack, input int s_at, input int s_len);
    logic [7:0] b [$];
    int   nab, ndb, nb, sent;
    txn_t t;
    nab = cfg ? 2 : 1;
    ndb = cfg ? 4 : 1;
    b.push_back({dev, 1'b0});
    for (int k = nab - 1; k >= 0; k--) b.push_back(8'((ra >> (8 * k)) & 32'hFF));
    for (int k = ndb - 1; k >= 0; k--) b.push_back(8'((wd >> (8 * k)) & 32'hFF));
    nb = b.size();
    sent = (nack >= 0 && nack < nb) ? nack + 1 : nb;
    for (int k = 0; k < sent; k++) exp_bytes.push_back(b[k]);
    t.err = (nack >= 0 && nack < nb);
    t.lat = DIV * (5 + 36 * sent) + ((s_at > 0) ? s_len : 0);
    t.cfg = cfg;
    exp_txn.push_back(t);
    nack_at = nack; stretch_at = s_at; stretch_len = s_len;

    @(negedge clk);
    chk("err_hold", cfg ? err_b : err_a, last_err[cfg]);
    if (cfg) begin
      dev_b = dev; reg_b = ra[15:0]; data_b = wd; start_b = 1'b1;
    end else begin
      dev_a = dev; reg_a = ra[7:0]; data_a = wd[7:0]; start_a = 1'b1;
    end
    t_start = cyc;
    txn_seen = 1'b0;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    // scramble inputs after the start is accepted: only the latched copy may be used
    dev_a = 7'($urandom); reg_a = 8'($urandom); data_a = 8'($urandom);
    dev_b = 7'($urandom); reg_b = 16'($urandom); data_b = $urandom;
    repeat (10) @(negedge clk);
    if (cfg) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 4000 && !txn_seen; i++) @(negedge clk);
    if (!txn_seen) begin
      chk("done_timeout", 1'b0, 1'b1);
      exp_bytes.delete(); exp_txn.delete(); abort = 1'b1;
    end
    last_err[cfg] = t.err;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int nb, nack, sent, s_at, s_len;
    logic cfg;

    repeat (3) @(negedge clk);
    chk("rst_sda_a", sda_out_a, 1'b1);
    chk("rst_scl_a", scl_out_a, 1'b1);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_done_a", done_a, 1'b0);
    chk("rst_err_a", err_a, 1'b0);
    chk("rst_sda_b", sda_out_b, 1'b1);
    chk("rst_busy_b", busy_b, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_txn(1'b0, 7'h39, 32'h41, 32'h10, -1, 0, 0);               // 452 cycles
    run_txn(1'b0, 7'h39, 32'h41, 32'h10, 0, 0, 0);                // address NACK, 164
    run_txn(1'b0, 7'h39, 32'h41, 32'h10, -1, 13, 50);             // stretch in byte1 bit3
    run_txn(1'b1, 7'h39, 32'hBEEF, 32'hDEADBEEF, -1, 0, 0);       // 1028 cycles

    // reset during byte1: only byte0 reaches the slave
    nack_at = -1; stretch_at = 0;
    exp_bytes.push_back({7'h2A, 1'b0});
    @(negedge clk);
    dev_a = 7'h2A; reg_a = 8'h55; data_a = 8'hAA; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (200) @(negedge clk);
    chk("busy_before_reset", busy_a, 1'b1);
    reset = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("midrst_sda", sda_out_a, 1'b1);
    chk("midrst_scl", scl_out_a, 1'b1);
    chk("midrst_busy", busy_a, 1'b0);
    chk("midrst_err", err_a, 1'b0);
    chk("midrst_done", done_a, 1'b0);
    chk("midrst_byte0", exp_bytes.size(), 0);
    reset = 1'b0;
    exp_bytes.delete();
    last_err[0] = 1'b0; last_err[1] = 1'b0;
    repeat (5) @(negedge clk);
    run_txn(1'b0, 7'h15, 32'hC3, 32'h5A, -1, 0, 0);

    for (int n = 0; n < 12; n++) begin
      cfg  = 1'($urandom);
      nb   = cfg ? 7 : 3;
      nack = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      sent = (nack >= 0) ? nack + 1 : nb;
      s_at = 0; s_len = 0;
      if ($urandom_range(0, 2) == 0) begin
        s_at  = $urandom_range(1, 9 * sent);
        s_len = $urandom_range(1, 40);
      end
      run_txn(cfg, 7'($urandom), $urandom, $urandom, nack, s_at, s_len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Parametrised I2C write-transaction master. Supersedes the fixed divide-by-256 SCL clock and the hard-wired open-drain SDA path.
- Runs on the system clock. SCL timing comes from a programmable clock-enable divider, not a derived clock.
- Issues START, device address (write), a register address of ADDR_W bits, a payload of DATA_W bits, then STOP.
- Checks every ACK and supports slave clock stretching.
- Drives pads through open-drain enables. Feeds the HDMI transmitter configuration sequencer.

Parameters:
- CLK_DIV, 125, system-clock cycles per quarter SCL bit period (>=2); 125 at 50 MHz gives 100 kHz.
- ADDR_W, 8, register address width in bits; multiple of 8, range 8..16.
- DATA_W, 8, write payload width in bits; multiple of 8, range 8..32.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- dev_addr  in  7  7-bit slave address; latched on accepted start.
- reg_addr  in  ADDR_W  register address; latched on accepted start.
- wdata  in  DATA_W  payload; latched on accepted start.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at transaction end, success or NACK.
- err  out  1  NACK seen in the last transaction.
- sda_in  in  1  SDA pad value.
- sda_out  out  1  1 releases SDA, 0 drives low.
- scl_in  in  1  SCL pad value, used for stretch detection.
- scl_out  out  1  1 releases SCL, 0 drives low.

Behaviour:
- Reset state: sda_out=1, scl_out=1, busy=0, done=0, err=0, divider=0, FSM=IDLE.
- Reset mid-transaction: all outputs return to reset values on the next edge. The bus is released; no STOP is generated.
- NBYTES = 1 + ADDR_W/8 + DATA_W/8.
- Shift order: byte0 = {dev_addr, 1'b0}, then reg_addr MSB byte first, then wdata MSB byte first. MSB-first within each byte.
- Start acceptance: start=1 with busy=0 latches the inputs, clears err, and sets busy=1 on the next cycle. start is ignored while busy=1.
- Quarter tick:
  - Divider counts 0..CLK_DIV-1 while busy=1.
  - Tick when the count reaches CLK_DIV-1; the count then wraps to 0.
  - Divider is held at 0 in IDLE.
- Clock stretch: whenever scl_out=1 and scl_in=0, the divider freezes and no tick occurs. Counting resumes when scl_in=1.
- FSM states, each advancing one quarter per tick:
  - IDLE: sda_out=1, scl_out=1.
  - START: 2 quarters.
    - Q0: SDA low, SCL high.
    - Q1: SDA low, SCL low.
  - BIT: 4 quarters per bit, 8 data bits per byte.
    - P0: SCL low; SDA set to the bit.
    - P1: SCL released.
    - P2: SCL released.
    - P3: SCL low.
  - ACK: 4 quarters, SCL pattern as BIT, SDA released.
    - sda_in is sampled on the tick ending P2.
    - 0: next byte, or STOP after the last byte.
    - 1: set err=1, go to STOP immediately; remaining bytes are skipped.
  - STOP: 3 quarters.
    - S0: SCL low, SDA low.
    - S1: SCL released, SDA low.
    - S2: SCL released, SDA released.
    - The tick ending S2 goes to DONE.
  - DONE: 1 cycle. done=1, busy=0 on that cycle, then IDLE. err holds until the next accepted start.
- Latency without stretch or NACK: done asserts exactly CLK_DIV*(5+36*NBYTES) cycles after the cycle in which start is accepted.
- SDA changes only while SCL is low, except the START and STOP edges.
- sda_in and scl_in are double-flopped internally. Stretch detection uses the synchronised scl_in; the 2-cycle lag is accepted.

Test Plan:
- Basic write, CLK_DIV=4, ADDR_W=8, DATA_W=8:
  - Stimulus: dev 0x39, reg 0x41, data 0x10, slave ACKs all bytes.
  - Bus carries bytes 0x72, 0x41, 0x10 with correct START/STOP.
  - done pulses after 452 cycles; err=0.
- Address NACK: slave leaves SDA high on the first ACK -> STOP follows directly after byte0, err=1, done pulses after 4*(5+36)=164 cycles.
- Clock stretch: slave holds scl_in low for 50 cycles during P1 of bit 3 of byte1 -> no SDA change during the hold, done delayed by exactly 50 cycles, data unchanged.
- Width sweep, ADDR_W=16, DATA_W=32:
  - Stimulus: reg 0xBEEF, data 0xDEADBEEF.
  - Bus carries bytes 0x72, BE, EF, DE, AD, BE, EF.
  - done pulses after 4*(5+252)=1028 cycles.
- Ignored start and mid-operation reset:
  - A start pulse while busy has no effect on latched data.
  - reset asserted during byte1 -> next cycle sda_out=1, scl_out=1, busy=0, err=0.
  - A new start then runs a clean transaction.
